instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: width of the IMEM word address output.
REQ-002 SHALL have parameter BASE_ADDR, default 0: first word address issued after reset or clear.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: clear  in  1  synchronous restart: address to BASE_ADDR, drop held word, clear err and full.
REQ-007 Port: in_valid  in  1  field bundle valid.
REQ-008 Port: in_ready  out  1  bundle accepted when in_valid && in_ready.
REQ-009 Port: fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-010 Port: opcode  in  7 / funct3  in  3 / funct7  in  7 / rs1, rs2, rd  in  5 each  instruction fields.
REQ-011 Port: imm  in  32  signed immediate (byte offset for B/J; full value for U).
REQ-012 Port: out_valid  out  1  encoded word valid.
REQ-013 Port: out_ready  in  1  consumer (IMEM writer) ready.
REQ-014 Port: out_instr  out  32  encoded instruction.
REQ-015 Port: out_addr  out  ADDR_W  IMEM word address for out_instr.
REQ-016 Port: err  out  1  sticky: at least one bundle was rejected.
REQ-017 Port: full  out  1  sticky: last address (all ones) has been issued.

Function
REQ-018 SHALL hold a one-entry output register; in_ready = !full && (!out_valid || out_ready) && !clear.
REQ-019 SHALL register the encoded word on acceptance: out_valid is 1 in the cycle after the accept edge (latency 1).
REQ-020 R encoding SHALL be funct7|rs2|rs1|funct3|rd|opcode.
REQ-021 I encoding SHALL be imm[11:0]|rs1|funct3|rd|opcode.
REQ-022 S encoding SHALL be imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
REQ-023 B encoding SHALL be imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
REQ-024 U encoding SHALL be imm[31:12]|rd|opcode.
REQ-025 J encoding SHALL be imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-026 Fields unused by a format (e.g. funct7 for I) SHALL be ignored.
REQ-027 Legality: I and S require imm in [-2048, 2047].
REQ-028 Legality: B requires imm in [-4096, 4094] and imm[0]=0.
REQ-029 Legality: J requires imm in [-2^20, 2^20-2] and imm[0]=0.
REQ-030 Legality: U requires imm[11:0]=0.
REQ-031 Legality: fmt 6 or 7 is illegal.
REQ-032 An illegal bundle SHALL still be accepted (handshake completes), produce no output word, set err, and leave the address unchanged.
REQ-033 The address counter SHALL start at BASE_ADDR and increment by 1 on each legal accept; out_addr is the address of the held word.
REQ-034 Accepting a legal bundle at address all-ones SHALL set full and SHALL NOT wrap; in_ready stays 0 until clear or reset.
REQ-035 While out_valid && !out_ready, out_instr and out_addr SHALL hold stable.
REQ-036 Simultaneous output handshake and input accept SHALL replace the held word in the same cycle, with no bubble.
REQ-037 clear SHALL take priority over any handshake in the same cycle: that output word is discarded and the input is not accepted.

Reset
REQ-038 On rst_n=0, asynchronously: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, full=0.
REQ-039 Reset mid-transfer SHALL discard the held word with no partial state retained; in_ready is 1 after reset release.

Verification
REQ-040 R: fmt=0, opcode=0x33, f3=0, f7=0, rs1=1, rs2=2, rd=3, out_ready=1 -> next cycle out_valid=1, out_instr=0x002081B3, out_addr=0.
REQ-041 I then B: fmt=1, opcode=0x13, rd=1, rs1=0, imm=-1 -> 0xFFF00093 @0; then fmt=3, opcode=0x63, rs1=rs2=0, imm=8 -> 0x00000463 @1.
REQ-042 Backpressure: out_ready=0, two bundles offered -> first held stable, in_ready=0, second not accepted; out_ready=1 -> second accepted and issued @next address, no bubble.
REQ-043 Error: fmt=3, imm=5 -> no out_valid, err=1, address unchanged; next legal bundle is issued at the same address; err stays 1 until clear.
REQ-044 Full: ADDR_W=2, four legal bundles -> addresses 0..3, full=1, in_ready=0; clear -> full=0, err=0, next word @0.
REQ-045 Reset mid-operation: rst_n low while out_valid=1 and out_ready=0 -> out_valid=0 immediately, out_addr=BASE_ADDR, err=0.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RISC-V field-bundle encoder feeding an IMEM writer
module instr_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic              full
);

  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              err_q, err_d;
  logic              full_q, full_d;

  logic [31:0] enc;
  logic        legal;
  logic        accept;
  logic        fits12;
  logic        fits13;
  logic        fits21;

  // An immediate fits an N-bit signed field when all bits above N-1 equal the sign bit.
  assign fits12 = (&imm[31:11]) || (~|imm[31:11]);
  assign fits13 = (&imm[31:12]) || (~|imm[31:12]);
  assign fits21 = (&imm[31:20]) || (~|imm[31:20]);

  assign in_ready = !full_q && (!out_valid_q || out_ready) && !clear;
  assign accept   = in_valid && in_ready;

  // Pack the fields for the requested format and judge whether the immediate is encodable.
  always_comb begin
    enc   = 32'd0;
    legal = 1'b0;
    case (fmt)
      3'd0: begin
        enc   = {funct7, rs2, rs1, funct3, rd, opcode};
        legal = 1'b1;
      end
      3'd1: begin
        enc   = {imm[11:0], rs1, funct3, rd, opcode};
        legal = fits12;
      end
      3'd2: begin
        enc   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal = fits12;
      end
      3'd3: begin
        enc   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal = fits13 && !imm[0];
      end
      3'd4: begin
        enc   = {imm[31:12], rd, opcode};
        legal = ~|imm[11:0];
      end
      3'd5: begin
        enc   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal = fits21 && !imm[0];
      end
      default: begin
        enc   = 32'd0;
        legal = 1'b0;
      end
    endcase
  end

  // Next state: clear beats everything, then input accept, then a lone output drain.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    next_addr_d = next_addr_q;
    err_d       = err_q;
    full_d      = full_q;
    if (clear) begin
      out_valid_d = 1'b0;
      out_instr_d = 32'd0;
      out_addr_d  = BASE;
      next_addr_d = BASE;
      err_d       = 1'b0;
      full_d      = 1'b0;
    end else if (accept) begin
      if (legal) begin
        out_valid_d = 1'b1;
        out_instr_d = enc;
        out_addr_d  = next_addr_q;
        if (next_addr_q == {ADDR_W{1'b1}}) begin
          full_d = 1'b1;
        end else begin
          next_addr_d = next_addr_q + 1'b1;
        end
      end else begin
        // Accept implies the held word (if any) was consumed this cycle.
        out_valid_d = 1'b0;
        err_d       = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_addr_q  <= BASE;
      next_addr_q <= BASE;
      err_q       <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      next_addr_q <= next_addr_d;
      err_q       <= err_d;
      full_q      <= full_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;
  assign full      = full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fmt;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [4:0]    rd;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err;
  logic          full;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .full(full)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: held word, its address, next address, sticky flags.
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_addr;
  int          m_next;
  bit          m_err;
  bit          m_full;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input int f, input int im);
    case (f)
      0:       return 1'b1;
      1, 2:    return (im >= -2048) && (im <= 2047);
      3:       return (im >= -4096) && (im <= 4094) && ((im & 1) == 0);
      4:       return (im & 32'hFFF) == 0;
      5:       return (im >= -(1 << 20)) && (im <= (1 << 20) - 2) && ((im & 1) == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_enc(input int f, input int op, input int f3, input int f7,
                                          input int r1, input int r2, input int rdd, input int im);
    logic [31:0] u;
    logic [31:0] base;
    u    = im;
    base = op + (rdd << 7);
    case (f)
      0: return base + (f3 << 12) + (r1 << 15) + (r2 << 20) + (f7 << 25);
      1: return base + (f3 << 12) + (r1 << 15) + ((u & 32'hFFF) << 20);
      2: return op + ((u & 32'h1F) << 7) + (f3 << 12) + (r1 << 15) + (r2 << 20)
                + (((u >> 5) & 32'h7F) << 25);
      3: return op + (((u >> 11) & 1) << 7) + (((u >> 1) & 32'hF) << 8) + (f3 << 12)
                + (r1 << 15) + (r2 << 20) + (((u >> 5) & 32'h3F) << 25) + (((u >> 12) & 1) << 31);
      4: return base + (u & 32'hFFFFF000);
      5: return base + (((u >> 12) & 32'hFF) << 12) + (((u >> 11) & 1) << 20)
                + (((u >> 1) & 32'h3FF) << 21) + (((u >> 20) & 1) << 31);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_instr = 32'd0;
    m_addr  = 0;
    m_next  = 0;
    m_err   = 1'b0;
    m_full  = 1'b0;
  endtask

  task automatic set_bundle(input int f, input int op, input int f3, input int f7,
                            input int r1, input int r2, input int rdd, input int im);
    fmt    = f[2:0];
    opcode = op[6:0];
    funct3 = f3[2:0];
    funct7 = f7[6:0];
    rs1    = r1[4:0];
    rs2    = r2[4:0];
    rd     = rdd[4:0];
    imm    = im;
  endtask

  // One clock: compare against the model at the falling edge, then advance the model.
  task automatic cycle();
    bit          exp_ready;
    bit          acc;
    bit          leg;
    logic [31:0] e;
    @(negedge clk);
    exp_ready = !m_full && (!m_valid || out_ready) && !clear;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("full", {31'd0, full}, {31'd0, m_full});
    if (m_valid) begin
      chk("out_instr", out_instr, m_instr);
      chk("out_addr", {30'd0, out_addr}, m_addr);
    end
    acc = in_valid && exp_ready;
    leg = ref_legal(int'(fmt), $signed(imm));
    e   = ref_enc(int'(fmt), int'(opcode), int'(funct3), int'(funct7),
                  int'(rs1), int'(rs2), int'(rd), $signed(imm));
    @(posedge clk);
    #1;
    if (clear) begin
      model_reset();
    end else if (acc) begin
      if (leg) begin
        m_valid = 1'b1;
        m_instr = e;
        m_addr  = m_next;
        if (m_next == (1 << AW) - 1) m_full = 1'b1;
        else m_next = m_next + 1;
      end else begin
        m_valid = 1'b0;
        m_err   = 1'b1;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  function automatic int pick_imm();
    int sel;
    sel = int'($urandom_range(0, 15));
    case (sel)
      0:  return -2048;
      1:  return 2047;
      2:  return 2048;
      3:  return -2049;
      4:  return -4096;
      5:  return 4094;
      6:  return 4095;
      7:  return -4098;
      8:  return (1 << 20) - 2;
      9:  return 1 << 20;
      10: return -(1 << 20);
      11: return int'($urandom) & 32'hFFFFF000;
      12: return int'($urandom);
      default: return int'($urandom_range(0, 8191)) - 4096;
    endcase
  endfunction

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_bundle(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", {30'd0, out_addr}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // R-type worked example
    set_bundle(0, 8'h33, 0, 0, 1, 2, 3, 0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("r_valid", {31'd0, out_valid}, 32'd1);
    chk("r_instr", out_instr, 32'h002081B3);
    chk("r_addr", {30'd0, out_addr}, 32'd0);
    cycle();

    // I then B from a cleared start
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    set_bundle(1, 8'h13, 0, 0, 0, 0, 1, -1);
    in_valid = 1'b1;
    cycle();
    chk("i_instr", out_instr, 32'hFFF00093);
    chk("i_addr", {30'd0, out_addr}, 32'd0);
    set_bundle(3, 8'h63, 0, 0, 0, 0, 0, 8);
    cycle();
    in_valid = 1'b0;
    chk("b_instr", out_instr, 32'h00000463);
    chk("b_addr", {30'd0, out_addr}, 32'd1);
    cycle();

    // Backpressure: second bundle waits, then goes in with no bubble
    clear = 1'b1;
    cycle();
    clear     = 1'b0;
    out_ready = 1'b0;
    set_bundle(0, 8'h33, 1, 7'h20, 4, 5, 6, 0);
    in_valid = 1'b1;
    cycle();
    set_bundle(1, 8'h13, 2, 0, 7, 0, 8, 100);
    cycle();
    cycle();
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_addr", {30'd0, out_addr}, 32'd0);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_next_addr", {30'd0, out_addr}, 32'd1);
    cycle();

    // Illegal B offset: error, no word, address kept
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    set_bundle(3, 8'h63, 0, 0, 1, 2, 0, 5);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("err_no_valid", {31'd0, out_valid}, 32'd0);
    chk("err_set", {31'd0, err}, 32'd1);
    set_bundle(4, 8'h37, 0, 0, 0, 0, 9, 32'h12345000);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("err_same_addr", {30'd0, out_addr}, 32'd0);
    chk("err_sticky", {31'd0, err}, 32'd1);
    cycle();

    // Fill the 2-bit address space, then clear
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_bundle(0, 8'h33, i, 0, i, i + 1, i + 2, 0);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("full_set", {31'd0, full}, 32'd1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("clr_full", {31'd0, full}, 32'd0);
    chk("clr_err", {31'd0, err}, 32'd0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("clr_addr", {30'd0, out_addr}, 32'd0);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      set_bundle(int'($urandom_range(0, 7)), int'($urandom), int'($urandom), int'($urandom),
                 int'($urandom), int'($urandom), int'($urandom), pick_imm());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 19) == 0);
      cycle();
    end
    clear    = 1'b0;
    in_valid = 1'b0;
    cycle();

    // Reset mid-transfer with err set and a word stalled
    clear = 1'b1;
    cycle();
    clear     = 1'b0;
    out_ready = 1'b0;
    set_bundle(5, 8'h6F, 0, 0, 0, 0, 1, 7);
    in_valid = 1'b1;
    cycle();
    set_bundle(5, 8'h6F, 0, 0, 0, 0, 1, 2048);
    cycle();
    cycle();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_addr", {30'd0, out_addr}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
